// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard.
// sb_entry_t describes one in-flight instruction as the scoreboard sees it.
// The FWD_* constants are the EX operand-mux select codes.
// hz_action_t names the hazard decision taken for the current cycle.
package hazard_pkg;

    // Register fields are stored at this fixed width. Narrower addresses are
    // zero-extended, so the struct does not depend on REG_AW.
    localparam int SB_RD_W = 8;

    localparam int FWD_RF    = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               reg_write;
        logic               is_load;
        logic               is_ctrl;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_BUSY,
        ACT_FLUSH,
        ACT_STALL,
        ACT_CTRL,
        ACT_RUN
    } hz_action_t;

    // An older instruction produces a register that ID reads.
    // Writes to x0 never count as a hit.
    function automatic logic entry_hits(input sb_entry_t e,
                                        input logic [SB_RD_W-1:0] rs,
                                        input logic used);
        return e.valid && e.reg_write && (e.rd == rs) && (e.rd != '0) && used;
    endfunction

endpackage

// File: rtl/hazard_sb_shift.sv
// Scoreboard shift register: entry[0] = EX, entry[PIPE_DEPTH-1] = WB.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   en            advance the pipeline by one stage
//   bubble        load an empty entry into EX instead of id_entry
//   clear0        kill the instruction leaving EX (wrong-path flush)
//   id_entry      descriptor of the instruction currently in ID
//   entries       all in-flight entries
module hazard_sb_shift
    import hazard_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       bubble,
    input  logic                       clear0,
    input  sb_entry_t                  id_entry,
    output sb_entry_t [PIPE_DEPTH-1:0] entries
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            entries <= '0;
        end else if (en) begin
            entries[0] <= bubble ? SB_EMPTY : id_entry;
            entries[1] <= clear0 ? SB_EMPTY : entries[0];
            for (int i = 2; i < PIPE_DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage RV32 pipeline.
// Inputs:
//   clk, rst                  clock, synchronous active-low reset
//   id_*                      decoded fields of the ID instruction
//   redirect                  taken branch or jump resolved in MEM
//   mem_busy                  data memory wait
// Outputs:
//   en_IF/en_IFID/en_pipe     stage enables
//   NOP_IFID/NOP_IDEX         bubble inserts
//   fwd_rs1_sel/fwd_rs2_sel   registered EX operand selects
//                             (0 = RF, 1 = EX/MEM, 2 = MEM/WB)
//   stall_cnt/flush_cnt       saturating performance counters
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int REG_AW     = 5,
    parameter  int PIPE_DEPTH = 3,
    parameter  int FWD_EN     = 1,
    parameter  int CTRL_MODE  = 0,
    parameter  int CNT_W      = 32,
    localparam int SEL_W      = $clog2(PIPE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_is_ctrl,
    input  logic              redirect,
    input  logic              mem_busy,
    output logic              en_IF,
    output logic              en_IFID,
    output logic              en_pipe,
    output logic              NOP_IFID,
    output logic              NOP_IDEX,
    output logic [SEL_W-1:0]  fwd_rs1_sel,
    output logic [SEL_W-1:0]  fwd_rs2_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    sb_entry_t [PIPE_DEPTH-1:0] entries;
    sb_entry_t                  id_entry;
    logic [SB_RD_W-1:0]         rs1;
    logic [SB_RD_W-1:0]         rs2;
    logic [PIPE_DEPTH-2:0]      hit1;
    logic [PIPE_DEPTH-2:0]      hit2;
    logic                       data_stall;
    logic                       ctrl_pending;
    logic [SEL_W-1:0]           rs1_sel_next;
    logic [SEL_W-1:0]           rs2_sel_next;
    hz_action_t                 action;

    // The WB entry and some flags of older entries are tracked but never compared.
    logic unused_entry_bits;
    assign unused_entry_bits = ^entries;

    assign rs1 = SB_RD_W'(id_rs1_addr);
    assign rs2 = SB_RD_W'(id_rs2_addr);

    assign id_entry.valid     = id_valid;
    assign id_entry.rd        = SB_RD_W'(id_rd_addr);
    assign id_entry.reg_write = id_reg_write;
    assign id_entry.is_load   = id_is_load;
    assign id_entry.is_ctrl   = id_is_ctrl;

    hazard_sb_shift #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .en       (en_pipe),
        .bubble   (NOP_IDEX),
        .clear0   (action == ACT_FLUSH),
        .id_entry (id_entry),
        .entries  (entries)
    );

    // The WB entry is excluded: the register file writes before ID reads.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
            hit1[i] = id_valid && entry_hits(entries[i], rs1, id_rs1_used);
            hit2[i] = id_valid && entry_hits(entries[i], rs2, id_rs2_used);
        end
    end

    // Walk from oldest to youngest so that the youngest producer wins.
    always_comb begin
        rs1_sel_next = SEL_W'(FWD_RF);
        rs2_sel_next = SEL_W'(FWD_RF);
        if (FWD_EN != 0) begin
            for (int i = PIPE_DEPTH - 2; i >= 0; i--) begin
                if (hit1[i]) rs1_sel_next = SEL_W'(FWD_EXMEM + i);
                if (hit2[i]) rs2_sel_next = SEL_W'(FWD_EXMEM + i);
            end
        end
    end

    // With forwarding, only a load in EX cannot be bypassed in time.
    assign data_stall = (FWD_EN != 0) ? ((hit1[0] | hit2[0]) & entries[0].is_load)
                                      : ((|hit1) | (|hit2));

    // A branch stays pending until it reaches MEM, where redirect resolves it.
    always_comb begin
        ctrl_pending = id_valid & id_is_ctrl;
        for (int i = 0; i <= PIPE_DEPTH - 3; i++) begin
            ctrl_pending = ctrl_pending | (entries[i].valid & entries[i].is_ctrl);
        end
    end

    always_comb begin
        if (!rst) begin
            action = ACT_RESET;
        end else if (mem_busy) begin
            action = ACT_BUSY;
        end else if ((CTRL_MODE == 1) && redirect) begin
            action = ACT_FLUSH;
        end else if (data_stall) begin
            action = ACT_STALL;
        end else if ((CTRL_MODE == 0) && ctrl_pending) begin
            action = ACT_CTRL;
        end else begin
            action = ACT_RUN;
        end
    end

    always_comb begin
        en_IF    = 1'b1;
        en_IFID  = 1'b1;
        en_pipe  = 1'b1;
        NOP_IFID = 1'b0;
        NOP_IDEX = 1'b0;
        case (action)
            ACT_BUSY: begin
                en_IF   = 1'b0;
                en_IFID = 1'b0;
                en_pipe = 1'b0;
            end
            ACT_FLUSH: begin
                NOP_IFID = 1'b1;
                NOP_IDEX = 1'b1;
            end
            ACT_STALL: begin
                en_IF    = 1'b0;
                en_IFID  = 1'b0;
                NOP_IDEX = 1'b1;
            end
            ACT_CTRL: begin
                en_IF    = 1'b0;
                NOP_IFID = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Selects follow the instruction into EX; a bubble carries the RF select.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_rs1_sel <= SEL_W'(FWD_RF);
            fwd_rs2_sel <= SEL_W'(FWD_RF);
        end else if (en_pipe) begin
            if (NOP_IDEX) begin
                fwd_rs1_sel <= SEL_W'(FWD_RF);
                fwd_rs2_sel <= SEL_W'(FWD_RF);
            end else begin
                fwd_rs1_sel <= rs1_sel_next;
                fwd_rs2_sel <= rs2_sel_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((action == ACT_STALL) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((action == ACT_FLUSH) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Three instances share one set of inputs:
//   index 0: forwarding, fetch hold on control
//   index 1: stall-only, fetch hold on control
//   index 2: forwarding, predict not-taken with flush
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd_addr;
    logic       id_reg_write;
    logic       id_is_load;
    logic       id_is_ctrl;
    logic       redirect;
    logic       mem_busy;

    logic        en_if    [3];
    logic        en_ifid  [3];
    logic        en_pipe  [3];
    logic        nop_ifid [3];
    logic        nop_idex [3];
    logic [1:0]  sel1     [3];
    logic [1:0]  sel2     [3];
    logic [31:0] stall_c  [3];
    logic [31:0] flush_c  [3];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_scoreboard #(
            .REG_AW     (5),
            .PIPE_DEPTH (3),
            .FWD_EN     ((g == 1) ? 0 : 1),
            .CTRL_MODE  ((g == 2) ? 1 : 0),
            .CNT_W      (32)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .id_valid     (id_valid),
            .id_rs1_addr  (id_rs1_addr),
            .id_rs2_addr  (id_rs2_addr),
            .id_rs1_used  (id_rs1_used),
            .id_rs2_used  (id_rs2_used),
            .id_rd_addr   (id_rd_addr),
            .id_reg_write (id_reg_write),
            .id_is_load   (id_is_load),
            .id_is_ctrl   (id_is_ctrl),
            .redirect     (redirect),
            .mem_busy     (mem_busy),
            .en_IF        (en_if[g]),
            .en_IFID      (en_ifid[g]),
            .en_pipe      (en_pipe[g]),
            .NOP_IFID     (nop_ifid[g]),
            .NOP_IDEX     (nop_idex[g]),
            .fwd_rs1_sel  (sel1[g]),
            .fwd_rs2_sel  (sel2[g]),
            .stall_cnt    (stall_c[g]),
            .flush_cnt    (flush_c[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic ld, input logic ctrl);
        id_valid     = v;
        id_rs1_addr  = r1;
        id_rs2_addr  = r2;
        id_rs1_used  = u1;
        id_rs2_used  = u2;
        id_rd_addr   = rd;
        id_reg_write = rw;
        id_is_load   = ld;
        id_is_ctrl   = ctrl;
    endtask

    task automatic idNop();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idOp(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(1'b1, r1, r2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idLoad(input logic [4:0] rd, input logic [4:0] r1);
        applyStimulus(1'b1, r1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idBranch(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(1'b1, r1, r2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        redirect = 1'b0;
        mem_busy = 1'b0;
        idNop();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset holds the enables high even while memory reports busy.
        rst = 1'b0;
        redirect = 1'b0;
        mem_busy = 1'b1;
        idLoad(5'd5, 5'd1);
        tick();
        #1;
        checkOutput("rst_en_if", en_if[0], 1);
        checkOutput("rst_en_pipe", en_pipe[0], 1);
        checkOutput("rst_nop_idex", nop_idex[0], 0);
        checkOutput("rst_sel1", sel1[0], 0);
        checkOutput("rst_stall_cnt", stall_c[0], 0);
        mem_busy = 1'b0;
        idNop();
        tick();
        rst = 1'b1;

        // ALU producer followed by dependent consumer: forward from EX/MEM.
        idOp(5'd5, 5'd1, 5'd2);
        #1;
        checkOutput("s1_prod_en_if", en_if[0], 1);
        tick();
        idOp(5'd6, 5'd5, 5'd1);
        #1;
        checkOutput("s1_cons_en_if", en_if[0], 1);
        checkOutput("s1_cons_nop_idex", nop_idex[0], 0);
        tick();
        idNop();
        #1;
        checkOutput("s1_fwd_rs1", sel1[0], 1);
        checkOutput("s1_fwd_rs2", sel2[0], 0);

        // Load-use with forwarding: one bubble, then forward from MEM/WB.
        doReset();
        idLoad(5'd5, 5'd1);
        tick();
        idOp(5'd6, 5'd5, 5'd0);
        #1;
        checkOutput("s2_stall_en_if", en_if[0], 0);
        checkOutput("s2_stall_en_ifid", en_ifid[0], 0);
        checkOutput("s2_stall_en_pipe", en_pipe[0], 1);
        checkOutput("s2_stall_nop_idex", nop_idex[0], 1);
        tick();
        #1;
        checkOutput("s2_go_en_if", en_if[0], 1);
        checkOutput("s2_go_nop_idex", nop_idex[0], 0);
        checkOutput("s2_bubble_sel1", sel1[0], 0);
        checkOutput("s2_stall_cnt_a", stall_c[0], 1);
        tick();
        idNop();
        #1;
        checkOutput("s2_fwd_rs1", sel1[0], 2);
        checkOutput("s2_fwd_rs2", sel2[0], 0);
        checkOutput("s2_stall_cnt_b", stall_c[0], 1);

        // Same load-use without forwarding: two bubbles, selects stay RF.
        doReset();
        idLoad(5'd5, 5'd1);
        tick();
        idOp(5'd6, 5'd5, 5'd0);
        #1;
        checkOutput("s3_stall1_nop_idex", nop_idex[1], 1);
        tick();
        #1;
        checkOutput("s3_stall2_nop_idex", nop_idex[1], 1);
        checkOutput("s3_stall2_en_if", en_if[1], 0);
        tick();
        #1;
        checkOutput("s3_go_en_if", en_if[1], 1);
        checkOutput("s3_go_nop_idex", nop_idex[1], 0);
        tick();
        idNop();
        #1;
        checkOutput("s3_sel1", sel1[1], 0);
        checkOutput("s3_stall_cnt", stall_c[1], 2);

        // Writes to x0 never create a dependency.
        doReset();
        idOp(5'd0, 5'd1, 5'd2);
        tick();
        idOp(5'd7, 5'd0, 5'd0);
        #1;
        checkOutput("s4_x0_nop_idex_fwd", nop_idex[0], 0);
        checkOutput("s4_x0_nop_idex_nofwd", nop_idex[1], 0);
        tick();
        idNop();
        #1;
        checkOutput("s4_x0_sel1", sel1[0], 0);
        checkOutput("s4_x0_sel2", sel2[0], 0);

        // Producer already in WB is read from the register file.
        doReset();
        idOp(5'd5, 5'd1, 5'd2);
        tick();
        idNop();
        tick();
        tick();
        idOp(5'd6, 5'd5, 5'd5);
        #1;
        checkOutput("s4_wb_nop_idex_nofwd", nop_idex[1], 0);
        checkOutput("s4_wb_en_if", en_if[0], 1);
        tick();
        idNop();
        #1;
        checkOutput("s4_wb_sel1", sel1[0], 0);
        checkOutput("s4_wb_sel2", sel2[0], 0);

        // Control hazards: hold mode vs predict-not-taken with flush.
        doReset();
        idBranch(5'd1, 5'd2);
        #1;
        checkOutput("s5_hold_en_if", en_if[0], 0);
        checkOutput("s5_hold_nop_ifid", nop_ifid[0], 1);
        checkOutput("s5_hold_en_ifid", en_ifid[0], 1);
        checkOutput("s5_pnt_en_if", en_if[2], 1);
        checkOutput("s5_pnt_nop_ifid", nop_ifid[2], 0);
        tick();
        idLoad(5'd5, 5'd1);
        tick();
        idOp(5'd6, 5'd5, 5'd0);
        #1;
        checkOutput("s5_pre_nop_idex", nop_idex[2], 1);
        redirect = 1'b1;
        #1;
        checkOutput("s5_flush_nop_ifid", nop_ifid[2], 1);
        checkOutput("s5_flush_nop_idex", nop_idex[2], 1);
        checkOutput("s5_flush_en_if", en_if[2], 1);
        tick();
        redirect = 1'b0;
        idNop();
        #1;
        checkOutput("s5_flush_cnt", flush_c[2], 1);
        checkOutput("s5_stall_cnt", stall_c[2], 0);

        // Memory wait in the middle of a load-use stall, then reset mid-stall.
        doReset();
        idLoad(5'd5, 5'd1);
        tick();
        idOp(5'd6, 5'd5, 5'd0);
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("s6_busy_en_if", en_if[0], 0);
            checkOutput("s6_busy_en_ifid", en_ifid[0], 0);
            checkOutput("s6_busy_en_pipe", en_pipe[0], 0);
            checkOutput("s6_busy_nop_idex", nop_idex[0], 0);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        checkOutput("s6_after_nop_idex", nop_idex[0], 1);
        checkOutput("s6_after_stall_cnt", stall_c[0], 0);
        checkOutput("s6_after_nop_idex_nofwd", nop_idex[1], 1);
        tick();
        #1;
        checkOutput("s6_cnt_fwd", stall_c[0], 1);
        checkOutput("s6_cnt_nofwd", stall_c[1], 1);
        checkOutput("s6_still_stall_nofwd", nop_idex[1], 1);
        rst = 1'b0;
        #1;
        checkOutput("s6_rst_en_if", en_if[1], 1);
        checkOutput("s6_rst_en_ifid", en_ifid[1], 1);
        checkOutput("s6_rst_nop_idex", nop_idex[1], 0);
        tick();
        #1;
        checkOutput("s6_rst_cnt_nofwd", stall_c[1], 0);
        checkOutput("s6_rst_cnt_fwd", stall_c[0], 0);
        rst = 1'b1;
        #1;
        checkOutput("s6_post_nop_idex", nop_idex[1], 0);
        checkOutput("s6_post_en_if", en_if[1], 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
